// File: rtl/ysyx_24080014_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24080014_mem_arbiter
//   Arbitrates a single shared memory port between the IFU (read-only) and
//   the LSU (load/store). One transaction is outstanding at a time. Ties are
//   broken round-robin, and a per-transaction watchdog aborts a stalled
//   transaction with an error response.
//
// Ports
//   clk, rst             : clock, asynchronous active-low reset
//   ifu_req_*/ifu_addr   : IFU read request (valid/ready)
//   ifu_rsp_*/ifu_rdata  : IFU response (valid, data, error)
//   lsu_req_*/lsu_*      : LSU request (addr, wen, wdata, wmask)
//   lsu_rsp_*/lsu_rdata  : LSU response (valid, data, error)
//   mem_req_*/mem_*      : shared memory request (valid/ready)
//   mem_rsp_valid/rdata  : shared memory response
//   busy                 : arbiter is not idle
// ---------------------------------------------------------------------------
module ysyx_24080014_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rsp_valid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_rsp_err,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_rsp_err,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e      r_state;
    state_e      w_state_nxt;
    owner_e      r_owner;
    owner_e      r_last_grant;
    logic [15:0] r_cnt;
    logic [31:0] r_addr;
    logic        r_wen;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;

    logic        w_grant_ifu;
    logic        w_grant_lsu;
    logic        w_done;
    logic        w_timeout;
    logic        w_rsp;
    logic [31:0] w_rsp_data;

    // Grants only while out of reset so req_ready stays low during reset.
    always_comb begin
        w_grant_ifu = 1'b0;
        w_grant_lsu = 1'b0;
        if (rst && r_state == S_IDLE) begin
            w_grant_ifu = ifu_req_valid && (!lsu_req_valid || r_last_grant == OWN_LSU);
            w_grant_lsu = lsu_req_valid && (!ifu_req_valid || r_last_grant == OWN_IFU);
        end
    end

    // Completion beats a coinciding timeout.
    assign w_done     = (r_state == S_WAIT) && mem_rsp_valid;
    assign w_timeout  = (r_state != S_IDLE) && (r_cnt == TMO_LAST) && !w_done;
    assign w_rsp      = w_done || w_timeout;
    assign w_rsp_data = w_done ? mem_rdata : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_grant_ifu || w_grant_lsu) w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_timeout)          w_state_nxt = S_IDLE;
                else if (mem_req_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: if (w_rsp) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_IFU;
            r_last_grant <= OWN_LSU;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_ifu) begin
                r_owner      <= OWN_IFU;
                r_last_grant <= OWN_IFU;
                r_cnt        <= '0;
                r_addr       <= ifu_addr;
                r_wen        <= 1'b0;
                r_wdata      <= '0;
                r_wmask      <= '0;
            end else if (w_grant_lsu) begin
                r_owner      <= OWN_LSU;
                r_last_grant <= OWN_LSU;
                r_cnt        <= '0;
                r_addr       <= lsu_addr;
                r_wen        <= lsu_wen;
                r_wdata      <= lsu_wdata;
                r_wmask      <= lsu_wmask;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        ifu_req_ready = w_grant_ifu;
        lsu_req_ready = w_grant_lsu;

        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_wen       = 1'b0;
        mem_wdata     = '0;
        mem_wmask     = '0;
        if (r_state == S_REQ) begin
            mem_req_valid = 1'b1;
            mem_addr      = r_addr;
            mem_wen       = r_wen;
            mem_wdata     = r_wdata;
            mem_wmask     = r_wmask;
        end

        ifu_rsp_valid = 1'b0;
        ifu_rdata     = '0;
        ifu_rsp_err   = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rdata     = '0;
        lsu_rsp_err   = 1'b0;
        if (w_rsp) begin
            if (r_owner == OWN_IFU) begin
                ifu_rsp_valid = 1'b1;
                ifu_rdata     = w_rsp_data;
                ifu_rsp_err   = w_timeout;
            end else begin
                lsu_rsp_valid = 1'b1;
                lsu_rdata     = w_rsp_data;
                lsu_rsp_err   = w_timeout;
            end
        end

        busy = (r_state != S_IDLE);
    end

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
module tb_ysyx_24080014_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, lsu_req_valid, lsu_wen;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_ready, mem_rsp_valid;

    logic        ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic        lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
    logic        mem_req_valid, mem_wen, busy;
    logic [3:0]  mem_wmask;

    logic        t_ifu_req_ready, t_ifu_rsp_valid, t_ifu_rsp_err;
    logic        t_lsu_req_ready, t_lsu_rsp_valid, t_lsu_rsp_err;
    logic [31:0] t_ifu_rdata, t_lsu_rdata, t_mem_addr, t_mem_wdata;
    logic        t_mem_req_valid, t_mem_wen, t_busy;
    logic [3:0]  t_mem_wmask;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    ysyx_24080014_mem_arbiter u_dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    ysyx_24080014_mem_arbiter #(.TIMEOUT(4)) u_dut_tmo (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(t_ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(t_ifu_rsp_valid), .ifu_rdata(t_ifu_rdata), .ifu_rsp_err(t_ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(t_lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(t_lsu_rsp_valid), .lsu_rdata(t_lsu_rdata), .lsu_rsp_err(t_lsu_rsp_err),
        .mem_req_valid(t_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(t_mem_addr),
        .mem_wen(t_mem_wen), .mem_wdata(t_mem_wdata), .mem_wmask(t_mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(t_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic rst_pulse;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    // One round-robin transaction with both requesters held valid and memory always ready.
    task automatic rr_txn(input logic exp_lsu, input logic [31:0] exp_addr, input logic [31:0] data);
        smp;
        check("rr_ifu_ready", 32'(ifu_req_ready), 32'(!exp_lsu));
        check("rr_lsu_ready", 32'(lsu_req_ready), 32'(exp_lsu));
        nxt;
        smp;
        check("rr_mem_valid", 32'(mem_req_valid), 32'd1);
        check("rr_mem_addr", mem_addr, exp_addr);
        check("rr_ready_req", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
        nxt;
        mem_rsp_valid = 1'b1;
        mem_rdata     = data;
        smp;
        check("rr_ifu_rsp", 32'(ifu_rsp_valid), 32'(!exp_lsu));
        check("rr_lsu_rsp", 32'(lsu_rsp_valid), 32'(exp_lsu));
        check("rr_ifu_rdata", ifu_rdata, exp_lsu ? 32'd0 : data);
        check("rr_lsu_rdata", lsu_rdata, exp_lsu ? data : 32'd0);
        nxt;
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;

        // Reset state: outputs quiet, req_ready held low even with a valid request.
        nxt;
        ifu_req_valid = 1'b1;
        smp;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        check("rst_ifu_ready", 32'(ifu_req_ready), 32'd0);
        check("rst_rsp", 32'({ifu_rsp_valid, lsu_rsp_valid}), 32'd0);
        nxt;

        // Single IFU fetch at minimum latency.
        rst = 1'b1;
        ifu_addr = 32'h8000_0000;
        mem_req_ready = 1'b1;
        smp;
        check("f_ifu_ready_c0", 32'(ifu_req_ready), 32'd1);
        check("f_lsu_ready_c0", 32'(lsu_req_ready), 32'd0);
        check("f_busy_c0", 32'(busy), 32'd0);
        nxt;
        ifu_req_valid = 1'b0;
        ifu_addr = 32'h1234_5678;
        smp;
        check("f_mem_valid_c1", 32'(mem_req_valid), 32'd1);
        check("f_mem_addr_c1", mem_addr, 32'h8000_0000);
        check("f_mem_wen_c1", 32'(mem_wen), 32'd0);
        check("f_mem_wmask_c1", 32'(mem_wmask), 32'd0);
        check("f_busy_c1", 32'(busy), 32'd1);
        nxt;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h0000_0413;
        smp;
        check("f_ifu_rsp_c2", 32'(ifu_rsp_valid), 32'd1);
        check("f_ifu_rdata_c2", ifu_rdata, 32'h0000_0413);
        check("f_ifu_err_c2", 32'(ifu_rsp_err), 32'd0);
        check("f_lsu_rsp_c2", 32'(lsu_rsp_valid), 32'd0);
        check("f_mem_valid_c2", 32'(mem_req_valid), 32'd0);
        nxt;
        mem_rsp_valid = 1'b0;
        smp;
        check("f_busy_c3", 32'(busy), 32'd0);
        check("f_ifu_rsp_c3", 32'(ifu_rsp_valid), 32'd0);
        check("f_ifu_rdata_c3", ifu_rdata, 32'd0);
        nxt;

        // Round-robin after reset: IFU, LSU, IFU, LSU.
        rst_pulse;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
        rr_txn(1'b0, 32'h8000_0010, 32'h1111_0001);
        rr_txn(1'b1, 32'h8000_2000, 32'h2222_0002);
        rr_txn(1'b0, 32'h8000_0010, 32'h3333_0003);
        rr_txn(1'b1, 32'h8000_2000, 32'h4444_0004);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;

        // LSU store with memory back-pressure; a stray response in REQ is dropped.
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        mem_req_ready = 1'b0;
        smp;
        check("s_lsu_ready", 32'(lsu_req_ready), 32'd1);
        nxt;
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                mem_rsp_valid = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
            end else begin
                mem_rsp_valid = 1'b0;
            end
            if (i == 3) mem_req_ready = 1'b1;
            smp;
            check("s_mem_valid", 32'(mem_req_valid), 32'd1);
            check("s_mem_addr", mem_addr, 32'h8000_1000);
            check("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("s_mem_wmask", 32'(mem_wmask), 32'h3);
            check("s_mem_wen", 32'(mem_wen), 32'd1);
            check("s_no_rsp_in_req", 32'({ifu_rsp_valid, lsu_rsp_valid}), 32'd0);
            nxt;
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        smp;
        check("s_wait_busy", 32'(busy), 32'd1);
        check("s_wait_mem_valid", 32'(mem_req_valid), 32'd0);
        nxt;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h0000_00AA;
        smp;
        check("s_lsu_rsp", 32'(lsu_rsp_valid), 32'd1);
        check("s_lsu_rdata", lsu_rdata, 32'h0000_00AA);
        check("s_ifu_rsp", 32'(ifu_rsp_valid), 32'd0);
        nxt;
        mem_rsp_valid = 1'b0;

        // Reset while in WAIT: aborts silently; late response dropped; IFU wins next tie.
        rst_pulse;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        mem_req_ready = 1'b1;
        nxt;
        ifu_req_valid = 1'b0;
        nxt;
        smp;
        check("r_wait_busy", 32'(busy), 32'd1);
        nxt;
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h5555_5555;
        #1;
        check("r_busy_now", 32'(busy), 32'd0);
        smp;
        check("r_no_ifu_rsp", 32'(ifu_rsp_valid), 32'd0);
        check("r_no_lsu_rsp", 32'(lsu_rsp_valid), 32'd0);
        check("r_ifu_rdata", ifu_rdata, 32'd0);
        nxt;
        rst = 1'b1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        smp;
        check("r_no_rsp_after", 32'({ifu_rsp_valid, lsu_rsp_valid}), 32'd0);
        check("r_tie_ifu", 32'(ifu_req_ready), 32'd1);
        check("r_tie_lsu", 32'(lsu_req_ready), 32'd0);
        nxt;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_rsp_valid = 1'b0;

        // TIMEOUT=4 instance: error response 4 cycles after grant, then IDLE.
        rst_pulse;
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_3000;
        mem_req_ready = 1'b1;
        mem_rdata = 32'h7777_7777;
        smp;
        check("t_grant", 32'(t_lsu_req_ready), 32'd1);
        nxt;
        lsu_req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            smp;
            check("t_no_rsp_early", 32'(t_lsu_rsp_valid), 32'd0);
            nxt;
        end
        smp;
        check("t_rsp_valid", 32'(t_lsu_rsp_valid), 32'd1);
        check("t_rsp_err", 32'(t_lsu_rsp_err), 32'd1);
        check("t_rsp_rdata", t_lsu_rdata, 32'd0);
        check("t_ifu_quiet", 32'(t_ifu_rsp_valid), 32'd0);
        nxt;
        smp;
        check("t_idle_busy", 32'(t_busy), 32'd0);
        check("t_rsp_one_cycle", 32'(t_lsu_rsp_valid), 32'd0);
        nxt;
        mem_rsp_valid = 1'b1;
        smp;
        check("t_late_dropped", 32'({t_ifu_rsp_valid, t_lsu_rsp_valid}), 32'd0);
        nxt;
        mem_rsp_valid = 1'b0;

        // TIMEOUT=4 instance: completion in the timeout cycle wins.
        rst_pulse;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_4000;
        smp;
        check("c_grant", 32'(t_ifu_req_ready), 32'd1);
        nxt;
        ifu_req_valid = 1'b0;
        nxt;
        nxt;
        nxt;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        smp;
        check("c_rsp_valid", 32'(t_ifu_rsp_valid), 32'd1);
        check("c_rsp_err", 32'(t_ifu_rsp_err), 32'd0);
        check("c_rsp_rdata", t_ifu_rdata, 32'hCAFE_F00D);
        nxt;
        mem_rsp_valid = 1'b0;
        smp;
        check("c_idle", 32'(t_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
